pipe_mem_stage: RTL and testbench

- Memory stage of the pipelined CPU. Consumes the EX/MEM register outputs (mwreg, mm2reg, mwmem, malu, mb, mrn).
- Performs the data-memory access over a variable-latency req/ack bus and stalls upstream while waiting.
- Aborts hung accesses via a watchdog and drives the MEM/WB register feeding write-back.

---
 rtl/pipe_mem_stage.sv | 144 ++++++++++++++
 tb/tb_pipe_mem_stage.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/pipe_mem_stage.sv
// Memory stage of the pipelined CPU: data-memory access over a variable-latency
// req/ack bus with upstream stall, watchdog abort and the MEM/WB register.
module pipe_mem_stage #(
   parameter int TIMEOUT = 16,
   parameter int CW      = 8
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic        mwreg,
   input  logic        mm2reg,
   input  logic        mwmem,
   input  logic [31:0] malu,
   input  logic [31:0] mb,
   input  logic [4:0]  mrn,
   output logic        mstall,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic        wwreg,
   output logic        wm2reg,
   output logic [31:0] wmo,
   output logic [31:0] walu,
   output logic [4:0]  wrn,
   output logic [1:0]  wexc
);

   typedef enum logic {IDLE, WAIT} state_t;

   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
   localparam logic [1:0]    EXC_NONE = 2'b00;
   localparam logic [1:0]    EXC_MIS  = 2'b01;
   localparam logic [1:0]    EXC_TMO  = 2'b10;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic        wwreg_q, wwreg_d;
   logic        wm2reg_q, wm2reg_d;
   logic [31:0] wmo_q, wmo_d;
   logic [31:0] walu_q, walu_d;
   logic [4:0]  wrn_q, wrn_d;
   logic [1:0]  wexc_q, wexc_d;

   logic in_wait, memop, mis, abort, done, is_load;

   // A load that also has mwmem set is treated as a store, so it returns no data.
   function automatic logic [31:0] load_data(input logic ld, input logic acked,
                                             input logic [31:0] rdata);
      return (ld && acked) ? rdata : 32'h0;
   endfunction

   always_comb begin
      in_wait    = (state_q == WAIT);
      memop      = mm2reg | mwmem;
      mis        = memop & (malu[1:0] != 2'b00) & ~in_wait;
      is_load    = mm2reg & ~mwmem;
      // Request/stall are forced low during reset so an in-flight access is dropped at once.
      dmem_req   = resetn & ((~in_wait & memop & ~mis) | in_wait);
      dmem_we    = mwmem;
      dmem_addr  = malu;
      dmem_wdata = mb;
      abort      = in_wait & ~dmem_ack & (cnt_q == CNT_LAST);
      done       = dmem_req & dmem_ack;
      mstall     = dmem_req & ~dmem_ack & ~abort;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (dmem_req && !dmem_ack) begin
               state_d = WAIT;
               cnt_d   = '0;
            end
         end
         WAIT: begin
            if (dmem_ack || abort) state_d = IDLE;
            else                   cnt_d   = cnt_q + CW'(1);
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      wwreg_d  = wwreg_q;
      wm2reg_d = wm2reg_q;
      wmo_d    = wmo_q;
      walu_d   = walu_q;
      wrn_d    = wrn_q;
      wexc_d   = EXC_NONE;
      if (mstall) begin
         wwreg_d  = 1'b0;
         wm2reg_d = 1'b0;
      end else if (mis || abort) begin
         wwreg_d  = 1'b0;
         wm2reg_d = 1'b0;
         wmo_d    = 32'h0;
         walu_d   = malu;
         wrn_d    = mrn;
         wexc_d   = mis ? EXC_MIS : EXC_TMO;
      end else begin
         wwreg_d  = mwreg;
         wm2reg_d = mm2reg;
         wmo_d    = load_data(is_load, done, dmem_rdata);
         walu_d   = malu;
         wrn_d    = mrn;
      end
   end

   // MEM -> WB stage boundary
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         wwreg_q  <= 1'b0;
         wm2reg_q <= 1'b0;
         wmo_q    <= 32'h0;
         walu_q   <= 32'h0;
         wrn_q    <= 5'h0;
         wexc_q   <= EXC_NONE;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         wwreg_q  <= wwreg_d;
         wm2reg_q <= wm2reg_d;
         wmo_q    <= wmo_d;
         walu_q   <= walu_d;
         wrn_q    <= wrn_d;
         wexc_q   <= wexc_d;
      end
   end

   assign wwreg  = wwreg_q;
   assign wm2reg = wm2reg_q;
   assign wmo    = wmo_q;
   assign walu   = walu_q;
   assign wrn    = wrn_q;
   assign wexc   = wexc_q;

endmodule

// File: tb/tb_pipe_mem_stage.sv
// Randomized self-checking bench for pipe_mem_stage against a per-instruction
// transaction model (request cycles, stall count, single MEM/WB result).
module tb_pipe_mem_stage;
   localparam int TO = 4;

   logic        clock = 1'b0;
   logic        resetn;
   logic        mwreg, mm2reg, mwmem;
   logic [31:0] malu, mb;
   logic [4:0]  mrn;
   logic        mstall, dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic        dmem_ack;
   logic        wwreg, wm2reg;
   logic [31:0] wmo, walu;
   logic [4:0]  wrn;
   logic [1:0]  wexc;

   int n_chk = 0;
   int n_err = 0;

   // last non-bubble MEM/WB payload, which bubbles must hold
   logic [31:0] p_alu, p_mo;
   logic [4:0]  p_rn;

   pipe_mem_stage #(.TIMEOUT(TO), .CW(8)) dut (
      .clock(clock), .resetn(resetn),
      .mwreg(mwreg), .mm2reg(mm2reg), .mwmem(mwmem),
      .malu(malu), .mb(mb), .mrn(mrn),
      .mstall(mstall), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
      .wwreg(wwreg), .wm2reg(wm2reg), .wmo(wmo), .walu(walu),
      .wrn(wrn), .wexc(wexc)
   );

   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_wb(input string tag, input logic e_wr, input logic e_m2r,
                           input logic [1:0] e_exc, input logic [31:0] e_alu,
                           input logic [4:0] e_rn, input logic [31:0] e_mo);
      check_eq({tag, ".wwreg"},  wwreg,  e_wr);
      check_eq({tag, ".wm2reg"}, wm2reg, e_m2r);
      check_eq({tag, ".wexc"},   wexc,   e_exc);
      check_eq({tag, ".walu"},   walu,   e_alu);
      check_eq({tag, ".wrn"},    wrn,    e_rn);
      check_eq({tag, ".wmo"},    wmo,    e_mo);
   endtask

   // Called at posedge+1. lat = request cycle carrying the ack (0 = never acked).
   task automatic run_instr(input logic wr, input logic m2r, input logic wm,
                            input logic [31:0] alu, input logic [31:0] b,
                            input logic [4:0] rn, input int lat, input logic noise);
      logic        memop, mis, acc, tmo;
      logic [31:0] rd, e_mo;
      int          ncyc;
      memop = m2r | wm;
      mis   = memop && (alu[1:0] != 2'b00);
      acc   = memop && !mis;
      tmo   = acc && !(lat >= 1 && lat <= TO + 1);
      if (!acc)     ncyc = 1;
      else if (tmo) ncyc = TO + 1;
      else          ncyc = lat;
      mwreg = wr; mm2reg = m2r; mwmem = wm; malu = alu; mb = b; mrn = rn;
      for (int k = 1; k <= ncyc; k++) begin
         rd         = $urandom;
         dmem_rdata = rd;
         dmem_ack   = acc ? (k == lat) : noise;
         #4;
         check_eq("req", dmem_req, acc);
         check_eq("stall", mstall, k < ncyc);
         if (acc) begin
            check_eq("we", dmem_we, wm);
            check_eq("addr", dmem_addr, alu);
            check_eq("wdata", dmem_wdata, b);
         end
         @(posedge clock); #1;
         if (k < ncyc) begin
            check_wb("bubble", 1'b0, 1'b0, 2'b00, p_alu, p_rn, p_mo);
         end else begin
            if (mis)      check_wb("mis", 1'b0, 1'b0, 2'b01, alu, rn, 32'h0);
            else if (tmo) check_wb("tmo", 1'b0, 1'b0, 2'b10, alu, rn, 32'h0);
            else begin
               e_mo = (m2r && !wm) ? rd : 32'h0;
               check_wb("done", wr, m2r, 2'b00, alu, rn, e_mo);
            end
            p_alu = alu;
            p_rn  = rn;
            p_mo  = (m2r && !wm && acc && !tmo) ? rd : 32'h0;
         end
      end
      dmem_ack = 1'b0;
   endtask

   initial begin
      logic [31:0] a;
      int          op;
      resetn = 1'b0;
      mwreg = 0; mm2reg = 0; mwmem = 0; malu = 0; mb = 0; mrn = 0;
      dmem_rdata = 0; dmem_ack = 0;
      p_alu = 0; p_rn = 0; p_mo = 0;
      #3;
      check_eq("rst.req", dmem_req, 1'b0);
      check_eq("rst.stall", mstall, 1'b0);
      check_wb("rst", 1'b0, 1'b0, 2'b00, 32'h0, 5'h0, 32'h0);
      #19 resetn = 1'b1;
      @(posedge clock); #1;

      run_instr(1, 0, 0, 32'h1234, 32'h0, 5'd5, 0, 1'b1);         // ALU op with stray ack
      run_instr(1, 1, 0, 32'h40, 32'h0, 5'd3, 1, 1'b0);           // zero-wait load
      run_instr(0, 0, 1, 32'h80, 32'hA5A5A5A5, 5'd0, 3, 1'b0);    // 3-cycle store
      run_instr(1, 1, 0, 32'h44, 32'h0, 5'd9, 0, 1'b0);           // load timeout
      run_instr(1, 1, 0, 32'h48, 32'h0, 5'd10, TO + 1, 1'b0);     // ack in abort cycle
      run_instr(1, 1, 0, 32'h42, 32'h0, 5'd11, 1, 1'b0);          // misaligned load
      run_instr(1, 0, 0, 32'h99, 32'h0, 5'd12, 0, 1'b0);          // wexc not sticky
      run_instr(1, 1, 1, 32'h100, 32'h5, 5'd13, 2, 1'b0);         // load+store = store

      // reset during the second request cycle of a stalled load
      mwreg = 1; mm2reg = 1; mwmem = 0; malu = 32'h200; mrn = 5'd7; dmem_ack = 0;
      @(posedge clock); #1;
      #2 resetn = 1'b0;
      #1;
      check_eq("rstw.req", dmem_req, 1'b0);
      check_eq("rstw.stall", mstall, 1'b0);
      check_wb("rstw", 1'b0, 1'b0, 2'b00, 32'h0, 5'h0, 32'h0);
      mwreg = 0; mm2reg = 0; mwmem = 0; malu = 0; mb = 0; mrn = 0;
      @(posedge clock); #2 resetn = 1'b1;
      @(posedge clock); #1;
      p_alu = 0; p_rn = 0; p_mo = 0;
      run_instr(1, 1, 0, 32'h300, 32'h0, 5'd8, 1, 1'b0);

      for (int i = 0; i < 300; i++) begin
         op = $urandom_range(0, 2);
         a  = $urandom;
         if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
         run_instr(1'($urandom), op == 1, op == 2, a, $urandom, 5'($urandom),
                   $urandom_range(0, TO + 2), 1'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
